// File: rtl/fpu_types_pkg.sv
// Shared half-precision types and constants for the FPU datapath.
// Holds the divider FSM encoding and the special result encodings.
package fpu_types_pkg;

    localparam int HALF_FLOAT_W    = 16;
    localparam int HALF_EXPONENT_W = 5;
    localparam int HALF_FRACTION_W = 10;

    typedef logic [HALF_EXPONENT_W-1:0] exp_t;
    typedef logic [HALF_FRACTION_W-1:0] mant_t;

    localparam logic [HALF_FLOAT_W-1:0] HALF_ZERO  = 16'h0000;
    localparam logic [HALF_FLOAT_W-1:0] HALF_ZERON = 16'h8000;
    localparam logic [HALF_FLOAT_W-1:0] HALF_QNAN  = 16'hFFFF;
    localparam logic [HALF_FLOAT_W-1:0] HALF_INF   = 16'h7C00;

    localparam int HALF_BIAS = 15;
    localparam int DIV_ITERS = 13;

    typedef enum logic [2:0] {
        DIV_IDLE  = 3'd0,
        DIV_NORM  = 3'd1,
        DIV_DIV   = 3'd2,
        DIV_ROUND = 3'd3,
        DIV_DONE  = 3'd4
    } div_state_t;

    // Left shift that moves the leading 1 of {1'b0, frac} up to bit 10.
    function automatic logic [3:0] lead_zero_shift(input mant_t frac);
        logic [3:0] sh;
        sh = 4'd0;
        for (int i = 0; i < HALF_FRACTION_W; i++) begin
            if (frac[i]) begin
                sh = 4'(10 - i);
            end
        end
        return sh;
    endfunction

endpackage

// File: rtl/mant_div_radix2.sv
// Iterative radix-2 restoring divider for 11-bit significands.
// Produces one quotient bit per cycle; q[12] is the integer bit.
module mant_div_radix2
    import fpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [10:0] ma,
    input  logic [10:0] mb,
    output logic [12:0] q,
    output logic        done
);

    logic [11:0] r_q;
    logic [11:0] r_sub;
    logic [11:0] r_d;
    logic [10:0] mb_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic [12:0] q_q;
    logic        q_bit;

    always_comb begin
        q_bit = (r_q >= {1'b0, mb_q});
        r_sub = q_bit ? (r_q - {1'b0, mb_q}) : r_q;
        r_d   = r_sub << 1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q    <= '0;
            mb_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            q_q    <= '0;
        end else if (start) begin
            r_q    <= {1'b0, ma};
            mb_q   <= mb;
            cnt_q  <= 4'(DIV_ITERS - 1);
            busy_q <= 1'b1;
            q_q    <= '0;
        end else if (busy_q) begin
            r_q <= r_d;
            q_q <= {q_q[11:0], q_bit};
            if (cnt_q == 4'd0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // High during the final iteration, so q is complete on the following cycle.
    assign done = busy_q && (cnt_q == 4'd0);
    assign q    = q_q;

endmodule

// File: rtl/float_div_16bit.sv
// Half-precision divider: special-case decode, significand normalisation,
// iterative mantissa division and half-up rounding with valid/ready handshakes.
module float_div_16bit
    import fpu_types_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [HALF_FLOAT_W-1:0] dividend,
    input  logic [HALF_FLOAT_W-1:0] divisor,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [HALF_FLOAT_W-1:0] quotient,
    output logic [2:0]              flags
);

    localparam logic [2:0] S_IDLE  = DIV_IDLE;
    localparam logic [2:0] S_NORM  = DIV_NORM;
    localparam logic [2:0] S_DIV   = DIV_DIV;
    localparam logic [2:0] S_ROUND = DIV_ROUND;
    localparam logic [2:0] S_DONE  = DIV_DONE;

    logic [2:0]              state_q, state_d;
    logic [14:0]             a_q, b_q;
    logic                    sign_q;
    logic signed [7:0]       e_q;
    logic [HALF_FLOAT_W-1:0] quotient_q;
    logic [2:0]              flags_q;

    // Operand classification and special-case resolution
    exp_t  ea, eb;
    mant_t fa, fb;
    logic  a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, in_sign;
    logic                    spec_hit;
    logic [HALF_FLOAT_W-1:0] spec_res;
    logic [2:0]              spec_flags;

    always_comb begin
        ea      = dividend[14:10];
        fa      = dividend[9:0];
        eb      = divisor[14:10];
        fb      = divisor[9:0];
        in_sign = dividend[15] ^ divisor[15];
        a_nan   = (&ea) && (|fa);
        a_inf   = (&ea) && !(|fa);
        a_zero  = !(|ea) && !(|fa);
        b_nan   = (&eb) && (|fb);
        b_inf   = (&eb) && !(|fb);
        b_zero  = !(|eb) && !(|fb);

        spec_hit   = 1'b1;
        spec_res   = HALF_QNAN;
        spec_flags = 3'b100;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res   = HALF_QNAN;
            spec_flags = 3'b100;
        end else if (b_zero && !a_inf) begin
            spec_res   = HALF_INF | {in_sign, 15'b0};
            spec_flags = 3'b010;
        end else if (a_inf) begin
            spec_res   = HALF_INF | {in_sign, 15'b0};
            spec_flags = 3'b000;
        end else if (a_zero || b_inf) begin
            spec_res   = in_sign ? HALF_ZERON : HALF_ZERO;
            spec_flags = 3'b000;
        end else begin
            spec_hit   = 1'b0;
            spec_flags = 3'b000;
        end
    end

    // Significand normalisation and unbiased-difference exponent
    logic [3:0]        sh_a, sh_b;
    logic [10:0]       ma_n, mb_n;
    logic signed [7:0] ea_eff, eb_eff, e_n;

    always_comb begin
        sh_a = lead_zero_shift(a_q[9:0]);
        sh_b = lead_zero_shift(b_q[9:0]);
        if (a_q[14:10] == 5'd0) begin
            ma_n   = {1'b0, a_q[9:0]} << sh_a;
            ea_eff = 8'sd1 - $signed({4'b0, sh_a});
        end else begin
            ma_n   = {1'b1, a_q[9:0]};
            ea_eff = $signed({3'b0, a_q[14:10]});
        end
        if (b_q[14:10] == 5'd0) begin
            mb_n   = {1'b0, b_q[9:0]} << sh_b;
            eb_eff = 8'sd1 - $signed({4'b0, sh_b});
        end else begin
            mb_n   = {1'b1, b_q[9:0]};
            eb_eff = $signed({3'b0, b_q[14:10]});
        end
        e_n = ea_eff - eb_eff + $signed(8'(HALF_BIAS));
    end

    logic [12:0] div_q;
    logic        div_done;

    mant_div_radix2 u_mant_div (
        .CLK   (CLK),
        .RST   (RST),
        .start (state_q == S_NORM),
        .ma    (ma_n),
        .mb    (mb_n),
        .q     (div_q),
        .done  (div_done)
    );

    // Rounding: normalise the quotient, denormalise if needed, round half-up
    logic [9:0]              mant_r, mant_s;
    logic                    guard_r, guard_s;
    logic signed [7:0]       e_r, e_base, e_fin;
    logic [7:0]              shamt;
    logic [10:0]             sub_bits, mant_inc;
    logic [HALF_FLOAT_W-1:0] round_res;
    logic [2:0]              round_flags;

    always_comb begin
        if (div_q[12]) begin
            mant_r  = div_q[11:2];
            guard_r = div_q[1];
            e_r     = e_q;
        end else begin
            mant_r  = div_q[10:1];
            guard_r = div_q[0];
            e_r     = e_q - 8'sd1;
        end

        shamt    = 8'd0;
        sub_bits = '0;
        if (e_r <= 8'sd0) begin
            // Shifts past the 12-bit window drain every bit, giving a signed zero.
            shamt    = 8'(8'sd1 - e_r);
            sub_bits = 11'({1'b1, mant_r, guard_r} >> shamt);
            mant_s   = sub_bits[10:1];
            guard_s  = sub_bits[0];
            e_base   = 8'sd0;
        end else begin
            mant_s   = mant_r;
            guard_s  = guard_r;
            e_base   = e_r;
        end

        mant_inc = {1'b0, mant_s} + {10'b0, guard_s};
        e_fin    = e_base + $signed({7'b0, mant_inc[10]});

        if (e_fin >= 8'sd31) begin
            round_res   = HALF_INF | {sign_q, 15'b0};
            round_flags = 3'b001;
        end else begin
            round_res   = {sign_q, e_fin[4:0], mant_inc[9:0]};
            round_flags = 3'b000;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = spec_hit ? S_DONE : S_NORM;
            S_NORM:  state_d = S_DIV;
            S_DIV:   if (div_done) state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            e_q        <= '0;
            quotient_q <= '0;
            flags_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && in_valid) begin
                a_q    <= dividend[14:0];
                b_q    <= divisor[14:0];
                sign_q <= in_sign;
                if (spec_hit) begin
                    quotient_q <= spec_res;
                    flags_q    <= spec_flags;
                end
            end
            if (state_q == S_NORM) begin
                e_q <= e_n;
            end
            if (state_q == S_ROUND) begin
                quotient_q <= round_res;
                flags_q    <= round_flags;
            end
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign quotient  = quotient_q;
    assign flags     = flags_q;

endmodule
